// File: rtl/stopwatch_timekeeper_pkg.sv
// Shared types and limits for the stopwatch timekeeper.
// Holds the FSM state, the time-of-count bundle and its increment rule.
package stopwatch_timekeeper_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        LAP    = 2'd3
    } sw_state_e;

    localparam int unsigned CS_MAX  = 99;
    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;
    localparam int unsigned HR_MAX  = 23;

    typedef struct packed {
        logic [4:0] hr;
        logic [5:0] min;
        logic [5:0] sec;
        logic [6:0] cs;
    } sw_time_t;

    // One centisecond step with full ripple carry and day wrap.
    function automatic sw_time_t time_inc(sw_time_t t);
        sw_time_t r;
        r = t;
        if (t.cs != 7'(CS_MAX)) begin
            r.cs = t.cs + 7'd1;
        end else begin
            r.cs = '0;
            if (t.sec != 6'(SEC_MAX)) begin
                r.sec = t.sec + 6'd1;
            end else begin
                r.sec = '0;
                if (t.min != 6'(MIN_MAX)) begin
                    r.min = t.min + 6'd1;
                end else begin
                    r.min = '0;
                    if (t.hr != 5'(HR_MAX)) r.hr = t.hr + 5'd1;
                    else                    r.hr = '0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_timekeeper_tick_divider.sv
// Modulo-(TERMINAL+1) counter with enable and synchronous clear.
// Emits a one-cycle tick while enabled at terminal count.
module tick_divider #(
    parameter int unsigned TERMINAL = 9
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned W = (TERMINAL > 0) ? $clog2(TERMINAL + 1) : 1;

    logic [W-1:0] count;

    assign tick = enable && (count == W'(TERMINAL));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_timekeeper.sv
// Stopwatch with run/pause/lap control and a free-running refresh toggle.
// Outputs are registered copies of the live count, frozen during LAP.
module stopwatch_timekeeper
    import stopwatch_timekeeper_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned REFRESH_HZ = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       lap_clear,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [6:0] centiseconds,
    output logic       clock_refresh,
    output logic       running
);

    localparam int unsigned CS_TERM  = CLK_HZ / 100 - 1;
    localparam int unsigned REF_TERM = CLK_HZ / (2 * REFRESH_HZ) - 1;

    sw_state_e state;
    sw_state_e state_next;
    logic      run_en;
    logic      idle_en;
    logic      lap_entry;
    logic      cs_tick;
    logic      ref_tick;
    sw_time_t  live_q;
    sw_time_t  lap_q;
    sw_time_t  disp_q;
    logic      running_q;
    logic      refresh_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // start_stop has priority over lap_clear.
    always_comb begin
        state_next = state;
        if (start_stop) begin
            unique case (state)
                IDLE:   state_next = RUN;
                RUN:    state_next = PAUSED;
                PAUSED: state_next = RUN;
                LAP:    state_next = PAUSED;
            endcase
        end else if (lap_clear) begin
            unique case (state)
                IDLE:   state_next = IDLE;
                RUN:    state_next = LAP;
                PAUSED: state_next = IDLE;
                LAP:    state_next = RUN;
            endcase
        end
    end

    always_comb begin
        run_en    = (state == RUN) || (state == LAP);
        idle_en   = (state == IDLE);
        lap_entry = (state != LAP) && (state_next == LAP);
    end

    tick_divider #(
        .TERMINAL(CS_TERM)
    ) u_cs_div (
        .clock  (clock),
        .reset  (reset),
        .enable (run_en),
        .clear  (idle_en),
        .tick   (cs_tick)
    );

    tick_divider #(
        .TERMINAL(REF_TERM)
    ) u_ref_div (
        .clock  (clock),
        .reset  (reset),
        .enable (1'b1),
        .clear  (1'b0),
        .tick   (ref_tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            live_q <= '0;
        end else if (state_next == IDLE) begin
            live_q <= '0;
        end else if (cs_tick) begin
            live_q <= time_inc(live_q);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lap_q     <= '0;
            disp_q    <= '0;
            running_q <= 1'b0;
            refresh_q <= 1'b0;
        end else begin
            if (lap_entry) lap_q <= live_q;
            disp_q    <= (state == LAP) ? lap_q : live_q;
            running_q <= run_en;
            refresh_q <= refresh_q ^ ref_tick;
        end
    end

    assign hours         = disp_q.hr;
    assign minutes       = disp_q.min;
    assign seconds       = disp_q.sec;
    assign centiseconds  = disp_q.cs;
    assign clock_refresh = refresh_q;
    assign running       = running_q;

endmodule
